mc_maindec: RTL
===============

# mc_maindec

Multicycle main control unit for the MIPS core, replacing the single-cycle opcode decoder with a Moore/Mealy state machine. It steps each instruction through fetch, decode, execute, memory and writeback states, stalls on a memory-ready handshake, and traps on illegal opcodes or memory timeouts. It sits between the instruction register's opcode field and the shared multicycle datapath: PC, IR, memory, register file and ALU muxes.

## Interface
- `MEM_WAIT_MAX`, default 0: max stall cycles per memory access before trap; 0 disables the timeout.
- `ALU_OP_W`, default 2: width of `alu_op`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_we`, `ir_we`, `mem_we`, `reg_we`  out  1 each  write enables
- `branch`  out  1  conditional PC write (datapath ANDs with zero)
- `iord`  out  1  memory address mux: 0 = PC, 1 = ALUOut
- `reg_dst`, `mem2reg`, `jal`  out  1 each  register-file write mux selects
- `alu_src_a`  out  1  ALU A mux select
- `alu_src_b`  out  2  ALU B mux select
- `pc_src`  out  2  PC source select
- `alu_op`  out  ALU_OP_W  ALU control (00 add, 01 sub, 10 funct)
- `illegal`, `timeout`  out  1 each  sticky trap causes
- `state_o`  out  4  current state, for debug

## Operation
- States and encodings, with the outputs each state drives (unlisted outputs are 0):
  - FETCH=0: alu_src_b=01, ir_we=pc_we=mem_ready.
  - DECODE=1: alu_src_b=11.
  - MEMADR=2: alu_src_a=1, alu_src_b=10.
  - MEMRD=3: iord=1.
  - MEMWB=4: mem2reg=1, reg_we=1.
  - MEMWR=5: iord=1, mem_we=1, held for the whole wait.
  - RTEX=6: alu_src_a=1, alu_op=10.
  - RTWB=7: reg_dst=1, reg_we=1.
  - BEQEX=8: alu_src_a=1, alu_op=01, pc_src=01, branch=1.
  - ADDIEX=9: alu_src_a=1, alu_src_b=10.
  - ADDIWB=10: reg_we=1.
  - JEX=11: pc_src=10, pc_we=1.
  - JALEX=12: pc_src=10, pc_we=1, reg_we=1, jal=1.
  - TRAP=13.
- Transitions:
  - FETCH→DECODE when mem_ready=1; otherwise stay in FETCH.
  - DECODE dispatches on opcode: 100011/101011→MEMADR, 000000→RTEX, 000100→BEQEX, 001000→ADDIEX, 000010→JEX, 000011→JALEX, anything else→TRAP with illegal:=1.
  - MEMADR→MEMRD for LW, →MEMWR for SW. The opcode is re-sampled here; the IR is stable.
  - MEMRD→MEMWB on mem_ready.
  - MEMWR→FETCH on mem_ready.
  - RTEX→RTWB, ADDIEX→ADDIWB.
  - MEMWB, RTWB, ADDIWB, BEQEX, JEX and JALEX all →FETCH.
  - TRAP is absorbing: all enables stay 0 until reset.
- Wait timer, active when MEM_WAIT_MAX>0:
  - Counts consecutive mem_ready=0 cycles in FETCH, MEMRD and MEMWR.
  - Clears on mem_ready=1 and on any state change.
  - A count of MEM_WAIT_MAX with mem_ready still 0 forces →TRAP and sets timeout:=1.
  - Counter width is clog2(MEM_WAIT_MAX+1); it saturates and never wraps.
  - If mem_ready=1 arrives on the final allowed cycle, the access completes and no trap is taken.

## Timing
- Reset values: state=FETCH, illegal=0, timeout=0, counter=0.
- While rst_n=0, all enables (pc_we, ir_we, mem_we, reg_we, branch) are forced to 0 combinationally. This covers reset asserted mid-access.
- Latency with mem_ready tied 1:
  - LW: 5 cycles.
  - SW, R-type, ADDI: 4 cycles.
  - BEQ, J, JAL: 3 cycles.
- Each memory stall cycle adds exactly 1 cycle.
- Output timing:
  - ir_we and pc_we in FETCH are Mealy on mem_ready; all other outputs are Moore on state.
  - illegal and timeout rise in the cycle TRAP is entered.

## Configuration
- `MC_MAINDEC_JAL_EN` defined: opcode 000011 dispatches to JALEX.
- `MC_MAINDEC_JAL_EN` undefined:
  - JALEX is not built.
  - 000011 is illegal and goes →TRAP.
  - The `jal` output is tied 0.

## Structure
- `mc_maindec_pkg` holds:
  - the 4-bit state enum;
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL);
  - ALU_OP codes and alu_src_b / pc_src select codes.
- One sub-module, `mc_maindec_wait_timer`, holds the MEM_WAIT_MAX counter and its timeout pulse. The top holds the state register, next-state logic and output decode.

## Test plan
- LW, mem_ready=1: state_o 0,1,2,3,4,0; reg_we=1 and mem2reg=1 only in cycle 5.
- SW, mem_ready=0 for 3 cycles in MEMWR: mem_we=1 for 4 consecutive cycles, then FETCH.
- Opcode 111111: DECODE→TRAP, illegal=1, all enables 0 for 20 cycles; rst_n pulse returns to FETCH with illegal=0.
- MEM_WAIT_MAX=4, mem_ready=0 in FETCH: TRAP after 4 stall cycles, timeout=1.
- Same configuration, mem_ready=1 on stall cycle 4: no trap, DECODE next.
- JAL: with the macro, JALEX with pc_we=reg_we=jal=1, 3 cycles total; without the macro, →TRAP with illegal=1.
- rst_n dropped during MEMWR: mem_we=0 in the same cycle, and state_o=0 after reset release.

Source files
------------

// File: rtl/mc_maindec_pkg.sv
// Shared types and constants for the multicycle MIPS main control unit:
// state encoding, opcode values and the datapath mux select codes.
package mc_maindec_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_JALEX  = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that sit on the memory handshake and may stall.
  function automatic logic is_mem_wait(state_e s);
    return s inside {S_FETCH, S_MEMRD, S_MEMWR};
  endfunction

endpackage

// File: rtl/mc_maindec_if.sv
// Control bundle between the main decoder and the multicycle datapath.
// slave: the decoder side; master: the datapath / stimulus side.
interface mc_maindec_if #(
  parameter int unsigned ALU_OP_W = 2
);
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_we;
  logic                ir_we;
  logic                mem_we;
  logic                reg_we;
  logic                branch;
  logic                iord;
  logic                reg_dst;
  logic                mem2reg;
  logic                jal;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          pc_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                illegal;
  logic                timeout;
  logic [3:0]          state_o;

  modport slave (
    input  opcode, mem_ready,
    output pc_we, ir_we, mem_we, reg_we, branch, iord, reg_dst, mem2reg,
           jal, alu_src_a, alu_src_b, pc_src, alu_op, illegal, timeout, state_o
  );

  modport master (
    output opcode, mem_ready,
    input  pc_we, ir_we, mem_we, reg_we, branch, iord, reg_dst, mem2reg,
           jal, alu_src_a, alu_src_b, pc_src, alu_op, illegal, timeout, state_o
  );
endinterface

// File: rtl/mc_maindec_wait_timer.sv
// Memory stall watchdog. Counts consecutive stalled cycles in a wait state
// and flags a timeout on the last allowed cycle if mem_ready is still low.
// MEM_WAIT_MAX = 0 removes the counter entirely.
module mc_maindec_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  if (MEM_WAIT_MAX == 0) begin : g_off
    logic unused_timer;
    assign unused_timer = ^{clk, rst_n, waiting_i, mem_ready_i};
    assign timeout_o    = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count stalled cycles; every exit from a wait state is either a
    // handshake or a trap, and non-wait states hold the count at zero.
    always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch forms.
      cnt_d = cnt_q;
      if (!waiting_i || mem_ready_i) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // This cycle would be stall number MEM_WAIT_MAX.
    assign timeout_o = waiting_i && !mem_ready_i && (cnt_q == CNT_LAST);
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback
// with a mem_ready handshake, illegal-opcode and memory-timeout traps.
// Optional feature: define MC_MAINDEC_JAL_EN to support JAL (opcode 000011);
// without it JAL is illegal and the jal output stays 0.
module mc_maindec
  import mc_maindec_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0,
  parameter int unsigned ALU_OP_W     = 2
) (
  input logic         clk,
  input logic         rst_n,
  mc_maindec_if.slave bus
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       waiting;
  logic       wait_timeout;
  logic       pc_we_s, ir_we_s, mem_we_s, reg_we_s, branch_s;
  logic [1:0] alu_op_s;

  assign waiting = is_mem_wait(state_q);

  mc_maindec_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .waiting_i  (waiting),
    .mem_ready_i(bus.mem_ready),
    .timeout_o  (wait_timeout)
  );

  // Next state and sticky trap causes.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_MAINDEC_JAL_EN
          OP_JAL:       state_d = S_JALEX;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      // The IR still holds the instruction, so the opcode is re-read here.
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_RTEX:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RTWB, S_ADDIWB, S_BEQEX, S_JEX: state_d = S_FETCH;
`ifdef MC_MAINDEC_JAL_EN
      S_JALEX:  state_d = S_FETCH;
`endif
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    if (wait_timeout) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end
  end

  // State and trap-cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Output decode: Moore on state, except FETCH's IR/PC writes follow mem_ready.
  always_comb begin
    pc_we_s       = 1'b0;
    ir_we_s       = 1'b0;
    mem_we_s      = 1'b0;
    reg_we_s      = 1'b0;
    branch_s      = 1'b0;
    alu_op_s      = ALU_ADD;
    bus.iord      = 1'b0;
    bus.reg_dst   = 1'b0;
    bus.mem2reg   = 1'b0;
    bus.jal       = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = SRCB_REG;
    bus.pc_src    = PC_ALU;
    case (state_q)
      S_FETCH: begin
        bus.alu_src_b = SRCB_FOUR;
        ir_we_s       = bus.mem_ready;
        pc_we_s       = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMRD:  bus.iord = 1'b1;
      S_MEMWB: begin
        bus.mem2reg = 1'b1;
        reg_we_s    = 1'b1;
      end
      S_MEMWR: begin
        bus.iord = 1'b1;
        mem_we_s = 1'b1;
      end
      S_RTEX: begin
        bus.alu_src_a = 1'b1;
        alu_op_s      = ALU_FUNCT;
      end
      S_RTWB: begin
        bus.reg_dst = 1'b1;
        reg_we_s    = 1'b1;
      end
      S_BEQEX: begin
        bus.alu_src_a = 1'b1;
        alu_op_s      = ALU_SUB;
        bus.pc_src    = PC_ALUOUT;
        branch_s      = 1'b1;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: reg_we_s = 1'b1;
      S_JEX: begin
        bus.pc_src = PC_JUMP;
        pc_we_s    = 1'b1;
      end
`ifdef MC_MAINDEC_JAL_EN
      S_JALEX: begin
        bus.pc_src = PC_JUMP;
        pc_we_s    = 1'b1;
        reg_we_s   = 1'b1;
        bus.jal    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Enables drop immediately while reset is held, even mid-access.
  assign bus.pc_we   = pc_we_s  & rst_n;
  assign bus.ir_we   = ir_we_s  & rst_n;
  assign bus.mem_we  = mem_we_s & rst_n;
  assign bus.reg_we  = reg_we_s & rst_n;
  assign bus.branch  = branch_s & rst_n;
  assign bus.alu_op  = ALU_OP_W'(alu_op_s);
  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;
  assign bus.state_o = state_q;

endmodule
